// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan decoder: active-low digit
// patterns, the decoded-digit record and the capture FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic [3:0] digit;
        logic       blank;
        logic       err;
        logic       dp;
    } seg7_digit_t;

    typedef enum logic {
        StCollect,
        StPublish
    } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Bundle between a multiplexed seven-segment display bus and its decoder.
// master drives the display lines, slave decodes and reports frames.
interface seven_seg_scan_decoder_if;

    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        stale;

    modport master (
        output an, seg, dp,
        input  value, blank, err, dp_out, frame_valid, stale
    );

    modport slave (
        input  an, seg, dp,
        output value, blank, err, dp_out, frame_valid, stale
    );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational map from an active-low segment pattern to a decoded digit record.
// Blank and illegal patterns both report digit 4'hF.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0]  seg,
    input  logic        dp,
    output seg7_digit_t decoded
);

    always_comb begin
        decoded.digit = 4'hF;
        decoded.blank = 1'b0;
        decoded.err   = 1'b0;
        decoded.dp    = ~dp;
        case (seg)
            SEG_0:     decoded.digit = 4'd0;
            SEG_1:     decoded.digit = 4'd1;
            SEG_2:     decoded.digit = 4'd2;
            SEG_3:     decoded.digit = 4'd3;
            SEG_4:     decoded.digit = 4'd4;
            SEG_5:     decoded.digit = 4'd5;
            SEG_6:     decoded.digit = 4'd6;
            SEG_7:     decoded.digit = 4'd7;
            SEG_8:     decoded.digit = 4'd8;
            SEG_9:     decoded.digit = 4'd9;
            SEG_BLANK: decoded.blank = 1'b1;
            default:   decoded.err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers four digits from a scanned seven-segment display and publishes them as frames.
// Define SEG_SCAN_DP_EN to capture the decimal point of each digit into dp_out.
module seven_seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic                     clk,
    input logic                     rst,
    seven_seg_scan_decoder_if.slave bus
);

    localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_MAX = 16'(TIMEOUT_CYCLES);

`ifdef SEG_SCAN_DP_EN
    localparam int unsigned SAMPLE_W = 12;
`else
    localparam int unsigned SAMPLE_W = 11;
`endif

    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] prev_q;
    logic [7:0]          stab_q, stab_d;
    logic                eligible;
    logic                changed;
    logic                capture;
    logic [1:0]          idx;
    logic [3:0]          cap_mask;
    logic                dec_dp;
    seg7_digit_t         decoded;

    scan_state_t         state_q;
    logic [3:0]          seen_q;
    logic [15:0]         shadow_value_q;
    logic [3:0]          shadow_blank_q;
    logic [3:0]          shadow_err_q;
    logic [15:0]         value_q;
    logic [3:0]          blank_q;
    logic [3:0]          err_q;
    logic                frame_valid_q;
    logic [15:0]         tmo_q;

`ifdef SEG_SCAN_DP_EN
    logic [3:0]          shadow_dp_q;
    logic [3:0]          dp_out_q;

    assign sample     = {bus.an, bus.seg, bus.dp};
    assign dec_dp     = bus.dp;
    assign bus.dp_out = dp_out_q;
`else
    logic                unused_dp;

    assign sample     = {bus.an, bus.seg};
    assign dec_dp     = 1'b1;
    assign unused_dp  = bus.dp ^ decoded.dp;
    assign bus.dp_out = 4'h0;
`endif

    seg7_pattern_decode u_decode (
        .seg     (bus.seg),
        .dp      (dec_dp),
        .decoded (decoded)
    );

    // Only a single active-low anode identifies which digit is on the bus.
    always_comb begin
        eligible = 1'b1;
        idx      = 2'd0;
        case (bus.an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: eligible = 1'b0;
        endcase
    end

    // The cycle that first shows a new pattern counts as its first stable cycle, so a
    // pattern held for STABLE_CYCLES cycles is captured on the last of them.
    always_comb begin
        changed = (sample != prev_q);
        stab_d  = stab_q;
        if (!eligible) begin
            stab_d = 8'd0;
        end else if (changed) begin
            stab_d = 8'd1;
        end else if (stab_q != STABLE_MAX) begin
            stab_d = stab_q + 8'd1;
        end
        capture  = eligible && (stab_d == STABLE_MAX) && (changed || (stab_q != STABLE_MAX));
        cap_mask = capture ? (4'b0001 << idx) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q         <= '0;
            stab_q         <= 8'd0;
            state_q        <= StCollect;
            seen_q         <= 4'h0;
            shadow_value_q <= 16'hFFFF;
            shadow_blank_q <= 4'hF;
            shadow_err_q   <= 4'h0;
            value_q        <= 16'hFFFF;
            blank_q        <= 4'hF;
            err_q          <= 4'h0;
            frame_valid_q  <= 1'b0;
            tmo_q          <= 16'd0;
`ifdef SEG_SCAN_DP_EN
            shadow_dp_q    <= 4'h0;
            dp_out_q       <= 4'h0;
`endif
        end else begin
            prev_q        <= sample;
            stab_q        <= stab_d;
            frame_valid_q <= 1'b0;

            if (frame_valid_q) begin
                tmo_q <= 16'd0;
            end else if (tmo_q != TIMEOUT_MAX) begin
                tmo_q <= tmo_q + 16'd1;
            end

            if (capture) begin
                shadow_value_q[{idx, 2'b00} +: 4] <= decoded.digit;
                shadow_blank_q[idx]               <= decoded.blank;
                shadow_err_q[idx]                 <= decoded.err;
`ifdef SEG_SCAN_DP_EN
                shadow_dp_q[idx]                  <= decoded.dp;
`endif
            end

            case (state_q)
                StCollect: begin
                    seen_q <= seen_q | cap_mask;
                    if ((seen_q | cap_mask) == 4'hF) begin
                        state_q <= StPublish;
                    end
                end
                StPublish: begin
                    // Publish the completed shadow; a same-cycle capture starts the next frame.
                    value_q       <= shadow_value_q;
                    blank_q       <= shadow_blank_q;
                    err_q         <= shadow_err_q;
`ifdef SEG_SCAN_DP_EN
                    dp_out_q      <= shadow_dp_q;
`endif
                    frame_valid_q <= 1'b1;
                    seen_q        <= cap_mask;
                    state_q       <= StCollect;
                end
                default: state_q <= StCollect;
            endcase
        end
    end

    assign bus.value       = value_q;
    assign bus.blank       = blank_q;
    assign bus.err         = err_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.stale       = (tmo_q == TIMEOUT_MAX);

endmodule
